// File: rtl/hex_sender.sv
`default_nettype none
// ============================================================================
//  Module   : hex_sender
//  Purpose  : On a rising edge of start, sends a captured value as ASCII hex
//             characters (MSB nibble first), optionally followed by CR LF,
//             into a UART TX FIFO with tx_full backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module hex_sender #(
    parameter int NDIGITS   = 4,
    parameter int NEWLINE   = 1,
    parameter int UPPERCASE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] value,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy
);

    localparam int               NCHAR      = NDIGITS + 2 * NEWLINE;
    localparam int               IDX_W      = 4;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHAR - 1);
    localparam logic [IDX_W-1:0] CR_IDX     = IDX_W'(NDIGITS);
    localparam logic [7:0]       ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic                  start_q,   start_d;
    logic [4*NDIGITS-1:0]  shadow_q,  shadow_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic                  wr_uart_q, wr_uart_d;
    logic [7:0]            w_data_q,  w_data_d;
    logic                  busy_q,    busy_d;

    logic                  start_edge;
    logic [3:0]            nibble;
    logic [7:0]            char_sel;

    assign start_edge = start & ~start_q;

    // Digit idx_q counts from the most significant nibble of the shadow copy.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = shadow_q[4*(NDIGITS-1-i) +: 4];
            end
        end
    end

    always_comb begin
        if (idx_q < CR_IDX) begin
            if (nibble < 4'd10) begin
                char_sel = 8'h30 + {4'h0, nibble};
            end else begin
                char_sel = ALPHA_BASE + {4'h0, nibble - 4'd10};
            end
        end else if (idx_q == CR_IDX) begin
            char_sel = 8'h0D;
        end else begin
            char_sel = 8'h0A;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = start;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        wr_uart_d = 1'b0;
        w_data_d  = w_data_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_edge) begin
                    shadow_d = value;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_full) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = char_sel;
                    state_d   = ST_GAP;
                end
            end
            // One idle cycle after each write so tx_full reflects that write.
            ST_GAP: begin
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SEND;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            shadow_q  <= '0;
            idx_q     <= '0;
            wr_uart_q <= 1'b0;
            w_data_q  <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            wr_uart_q <= wr_uart_d;
            w_data_q  <= w_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_uart = wr_uart_q;
    assign w_data  = w_data_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_sender
//  Purpose  : Directed, table-driven bench for hex_sender in three
//             configurations (4/CRLF/upper, 4/no-CRLF/lower, 1/CRLF/upper).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hex_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [3];
    logic [31:0] val   [3];
    logic        full  [3];
    logic        wr    [3];
    logic [7:0]  wd    [3];
    logic        bsy   [3];

    always #5 clk = ~clk;

    hex_sender #(.NDIGITS(4), .NEWLINE(1), .UPPERCASE(1)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .value(val[0][15:0]),
        .tx_full(full[0]), .wr_uart(wr[0]), .w_data(wd[0]), .busy(bsy[0]));

    hex_sender #(.NDIGITS(4), .NEWLINE(0), .UPPERCASE(0)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .value(val[1][15:0]),
        .tx_full(full[1]), .wr_uart(wr[1]), .w_data(wd[1]), .busy(bsy[1]));

    hex_sender #(.NDIGITS(1), .NEWLINE(1), .UPPERCASE(1)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .value(val[2][3:0]),
        .tx_full(full[2]), .wr_uart(wr[2]), .w_data(wd[2]), .busy(bsy[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte capture: every write strobe is logged with the cycle it appeared in.
    logic [7:0] got    [3][16];
    int         got_wr [3][16];
    int         got_n  [3];
    logic       prev_wr[3];
    int         dbl_wr = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (wr[d] === 1'b1) begin
                if (got_n[d] < 16) begin
                    got[d][got_n[d]]    = wd[d];
                    got_wr[d][got_n[d]] = cyc;
                end
                got_n[d] = got_n[d] + 1;
                if (prev_wr[d] === 1'b1) dbl_wr = dbl_wr + 1;
            end
            prev_wr[d] = wr[d];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Raises start on DUT d and returns the cycle number of the sampling edge.
    task automatic kick(input int d, input logic [31:0] v, output int e0);
        @(negedge clk); #1;
        got_n[d] = 0;
        val[d]   = v;
        start[d] = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
    endtask

    // fb: index of the byte held off by tx_full for fl cycles (fb large = none).
    task automatic run_seq(input int d, input logic [31:0] v, input int fb, input int fl,
                           output int e0, output int done);
        int rel;
        kick(d, v, e0);
        done = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rel      = cyc - e0;
            start[d] = 1'b0;
            full[d]  = (rel >= 2 * fb) && (rel < 2 * fb + fl);
            if (bsy[d] !== 1'b1) begin
                done = rel;
                break;
            end
        end
        full[d] = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int d, input int e0, input int done,
                             input int n, input logic [79:0] b, input int fb, input int fl,
                             input int exp_done);
        chk({tag, ".count"}, got_n[d], n);
        for (int k = 0; k < n && k < 16; k++) begin
            chk($sformatf("%s.byte%0d", tag, k), {24'h0, got[d][k]}, {24'h0, b[79-8*k -: 8]});
            chk($sformatf("%s.wr_at%0d", tag, k), got_wr[d][k] - e0,
                2 * k + 1 + ((k >= fb) ? fl : 0));
        end
        if (exp_done >= 0) chk({tag, ".busy_low_at"}, done, exp_done);
    endtask

    typedef struct {
        int          d;
        logic [31:0] v;
        int          fb;
        int          fl;
        int          n;
        logic [79:0] b;
        int          done;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int e0, done;

        tbl[0] = '{0, 32'h1A2F, 99, 0, 6, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A, 32'h0}, 12};
        tbl[1] = '{0, 32'h1A2F, 1,  5, 6, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A, 32'h0}, 17};
        tbl[2] = '{0, 32'h0000, 99, 0, 6, {8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 32'h0}, 12};
        tbl[3] = '{0, 32'hFFFF, 99, 0, 6, {8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A, 32'h0}, 12};
        tbl[4] = '{1, 32'hBEEF, 99, 0, 4, {8'h62, 8'h65, 8'h65, 8'h66, 48'h0}, 8};
        tbl[5] = '{1, 32'hA05C, 2,  3, 4, {8'h61, 8'h30, 8'h35, 8'h63, 48'h0}, 11};
        tbl[6] = '{2, 32'h0009, 99, 0, 3, {8'h39, 8'h0D, 8'h0A, 56'h0}, 6};

        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; val[d] = '0; full[d] = 1'b0; got_n[d] = 0; prev_wr[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset.wr%0d", d),   {31'h0, wr[d]},  32'h0);
            chk($sformatf("reset.data%0d", d), {24'h0, wd[d]},  32'h0);
            chk($sformatf("reset.busy%0d", d), {31'h0, bsy[d]}, 32'h0);
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_seq(tbl[i].d, tbl[i].v, tbl[i].fb, tbl[i].fl, e0, done);
            check_seq($sformatf("vec%0d", i), tbl[i].d, e0, done, tbl[i].n, tbl[i].b,
                      tbl[i].fb, tbl[i].fl, tbl[i].done);
            repeat (3) @(negedge clk);
        end

        // start held for 100 cycles, value changed mid-sequence
        kick(0, 32'h1A2F, e0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 4) val[0] = 32'h5555;
        end
        start[0] = 1'b0;
        check_seq("hold", 0, e0, -1, 6, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A, 32'h0}, 99, 0, -1);
        chk("hold.busy_end", {31'h0, bsy[0]}, 32'h0);
        repeat (3) @(negedge clk);

        // extra start edges while busy must be dropped
        kick(0, 32'h1A2F, e0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3 || k == 6 || k == 9) start[0] = 1'b0;
            if (k == 5 || k == 8)           start[0] = 1'b1;
        end
        check_seq("retrig", 0, e0, -1, 6, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A, 32'h0}, 99, 0, -1);

        // asynchronous reset right after the second byte
        kick(0, 32'h1A2F, e0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            start[0] = 1'b0;
            if (got_n[0] >= 2) break;
        end
        chk("abort.count_before", got_n[0], 2);
        rst = 1'b0;
        #1;
        chk("abort.wr",   {31'h0, wr[0]},  32'h0);
        chk("abort.data", {24'h0, wd[0]},  32'h0);
        chk("abort.busy", {31'h0, bsy[0]}, 32'h0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort.no_more_writes", got_n[0], 2);
        run_seq(0, 32'h1A2F, 99, 0, e0, done);
        check_seq("restart", 0, e0, done, 6, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A, 32'h0}, 99, 0, 12);

        chk("no_back_to_back", dbl_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_sender.md
# hex_sender

Transmit-side companion to the UART receive path. On a rising edge of `start`, the block captures an `NDIGITS`-nibble value, converts each nibble to an ASCII hex character (MSB nibble first), and optionally appends CR LF. It pushes each byte into the UART transmit FIFO one write at a time, using the FIFO's `tx_full` flag as backpressure. It sits between the user inputs (switches/button) and the UART TX FIFO write port.

## Interface
- `NDIGITS`, default 4: number of hex characters sent. Legal range 1..8.
- `NEWLINE`, default 1: when 1, append 0x0D then 0x0A after the digits. When 0, send digits only.
- `UPPERCASE`, default 1: when 1, nibbles 10..15 map to 0x41..0x46 ('A'..'F'). When 0, they map to 0x61..0x66 ('a'..'f').

Ports (clock and reset first):
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low. One clock; the reset is asynchronous and active-low.
- `start`  in  1: send request. Level input; a sequence starts on a rising edge only.
- `value`  in  4*NDIGITS: value to send. Sampled only at the start edge.
- `tx_full`  in  1: UART TX FIFO full flag. No write is issued while it is high.
- `wr_uart`  out  1: TX FIFO write strobe. Registered; one-cycle pulse per byte.
- `w_data`  out  8: TX FIFO write data. Registered; valid in every cycle `wr_uart`=1.
- `busy`  out  1: high while a sequence is in progress.

## Operation
- Total characters per sequence: NCHAR = NDIGITS + 2*NEWLINE.
- Registers: `start_q`, `shadow` (4*NDIGITS bits), character index `idx`, state, and the outputs.
- Start edge: `start`=1 and `start_q`=0. `start_q` is updated every cycle regardless of state.
- States:
  - IDLE: `busy`=0. On a start edge: `shadow`<=`value`, `idx`<=0, `busy`<=1, go to SEND.
  - SEND: if `tx_full`=0, then `wr_uart`<=1, `w_data`<=char(`idx`), go to GAP. If `tx_full`=1, hold state; `wr_uart` stays 0.
  - GAP: `wr_uart`<=0. If `idx`=NCHAR-1, then `busy`<=0 and go to IDLE. Otherwise `idx`<=`idx`+1 and go to SEND.
- The GAP cycle lets the FIFO's `tx_full` settle after each write. No two consecutive cycles ever have `wr_uart`=1.
- Character mapping:
  - For `idx` < NDIGITS, the nibble is `shadow`[4*(NDIGITS-1-idx) +: 4].
  - Nibbles 0..9 map to 0x30+n.
  - Nibbles 10..15 map to 0x41+n-10 (uppercase) or 0x61+n-10 (lowercase).
  - `idx`=NDIGITS gives 0x0D; `idx`=NDIGITS+1 gives 0x0A.
- Start edges while `busy`=1 are ignored. No request is queued.
- Changes on `value` after the start edge do not affect the current sequence.
- `w_data` holds its last value when `wr_uart`=0.

## Timing
- Reset (`rst`=0, async): state=IDLE, `wr_uart`=0, `w_data`=0x00, `busy`=0, `start_q`=0, `shadow`=0, `idx`=0.
- If `start` is high when reset is released, the first clock sees a start edge, because `start_q`=0.
- Latency, with start edge sampled at edge E0 and `tx_full`=0 throughout:
  - `busy` rises after E0.
  - `wr_uart` pulses after E1, E3, …, E(2*NCHAR-1).
  - `busy` falls after E(2*NCHAR).
  - The next start edge is accepted at E(2*NCHAR+1) or later.
- Backpressure: each cycle `tx_full`=1 in SEND adds exactly one cycle of delay. Byte order and content are unchanged.
- `tx_full` is ignored in GAP and IDLE.
- Reset mid-sequence aborts immediately. Remaining characters are never sent, and the next sequence starts fresh at `idx`=0.

## Test plan
- NDIGITS=4, NEWLINE=1, UPPERCASE=1, `value`=0x1A2F, `tx_full`=0, one start pulse:
  - Bytes are 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A.
  - `wr_uart` pulses at cycles 1, 3, 5, 7, 9, 11 after the edge.
  - `busy` is low after cycle 12.
- Backpressure: same stimulus with `tx_full` high for 5 cycles just before the second byte.
  - No `wr_uart` while full.
  - Identical 6-byte sequence, finishing 5 cycles later.
- `start` held high for 100 cycles and `value` changed mid-sequence:
  - Exactly one sequence is sent.
  - Bytes reflect the value at the edge.
  - Start pulses while busy produce no extra bytes.
- Async reset asserted after the second byte:
  - All outputs go to 0 immediately, with no further writes.
  - A new start sends the full sequence from the first digit.
- UPPERCASE=0, NEWLINE=0, `value`=0xBEEF: bytes are 0x62, 0x65, 0x65, 0x66, then `busy` is low after 8 cycles.
- Boundary values: `value`=0x0000 gives 0x30 ×4; `value`=0xFFFF gives 0x46 ×4. NDIGITS=1 with `value`=0x9 gives 0x39, 0x0D, 0x0A.
